serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: diff = x - y - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshakes, one result bit per clock, LSB first.
// Define SERIAL_SUB_BORROW_IN_EN to add a borrow-in port (bin) sampled with the operands.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             diff_bit;
  logic             borrow_next;
  logic             borrow_init;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign borrow_init = bin;
`else
  assign borrow_init = 1'b0;
`endif

  full_subtractor u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .diff (diff_bit),
    .bout (borrow_next)
  );

  assign d = {borrow, res};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            res      <= '0;
            borrow   <= borrow_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
          res    <= {diff_bit, res[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against an arithmetic model.
// Honours SERIAL_SUB_BORROW_IN_EN when the design is built with the borrow-in option.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bin       (bin_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a-b-bin as plain integer arithmetic, truncated to WIDTH+1 bits.
  function automatic logic [W:0] model(input int av, input int bv, input int cv);
    int r;
    r = av - bv - cv;
    return (W+1)'(r);
  endfunction

  task automatic run_op(input int av, input int bv, input int cv, input int hold);
    logic [W:0] exp;
    int n;
    exp = model(av, bv, cv);
`ifndef SERIAL_SUB_BORROW_IN_EN
    exp = model(av, bv, 0);
`endif
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = W'(av);
    b        = W'(bv);
    bin_in   = cv[0];
    @(negedge clk);
    check("shift_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      a      = W'($urandom);
      b      = W'($urandom);
      bin_in = 1'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(W));
    check("result", 32'(d), 32'(exp));
    check("done_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_d", 32'(d), 32'(exp));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("exit_valid", 32'(out_valid), 32'd0);
    check("exit_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin_in    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);

    run_op(9, 3, 0, 0);
    check("9-3", 32'(d), 32'b00110);
    run_op(3, 9, 0, 0);
    check("3-9", 32'(d), 32'b11010);
    run_op(15, 15, 0, 0);
    run_op(0, 0, 0, 1);
    run_op(0, 15, 0, 0);
    check("0-15", 32'(d), 32'b10001);
    run_op(12, 5, 0, 5);

    // Abort mid-operation: reset after two shift edges.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd11;
    b = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    seen_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    check("abort_no_pulse", 32'(seen_valid), 32'd0);
    run_op(7, 2, 0, 0);
    check("7-2", 32'(d), 32'b00101);

`ifdef SERIAL_SUB_BORROW_IN_EN
    run_op(5, 0, 1, 0);
    check("5-0-1", 32'(d), 32'b00100);
    run_op(0, 0, 1, 0);
    check("0-0-1", 32'(d), 32'b11111);
`endif

    for (int k = 0; k < 20; k++) begin
      run_op(int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
